// File: rtl/avalon_bus_read_verify_if.sv
// Avalon-MM read port bundle for the frame-buffer read-back checker.
interface avalon_bus_read_verify_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
) ();
    logic              avl_waitrequest_n;
    logic [DATA_W-1:0] avl_readdata;
    logic              avl_readdatavalid;
    logic [ADDR_W-1:0] avl_address;
    logic              avl_read;
    logic              avl_burstbegin;

    modport master (
        input  avl_waitrequest_n,
        input  avl_readdata,
        input  avl_readdatavalid,
        output avl_address,
        output avl_read,
        output avl_burstbegin
    );

    modport slave (
        output avl_waitrequest_n,
        output avl_readdata,
        output avl_readdatavalid,
        input  avl_address,
        input  avl_read,
        input  avl_burstbegin
    );
endinterface

// File: rtl/avalon_bus_read_verify.sv
// Reads back NUM_WORDS words and checks data == address after the fill test.
module avalon_bus_read_verify #(
    parameter int ADDR_W          = 27,
    parameter int DATA_W          = 32,
    parameter int NUM_WORDS       = 2073600,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                   iCLK,
    input  logic                   iRST_n,
    input  logic                   iBUTTON,
    input  logic                   local_init_done,
    avalon_bus_read_verify_if.master avl,
    output logic                   drv_status_test_complete,
    output logic                   drv_status_test_pass,
    output logic [15:0]            err_count,
    output logic [ADDR_W-1:0]      first_err_addr,
    output logic [3:0]             c_state
);
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        READ  = 4'd1,
        DRAIN = 4'd2,
        DONE  = 4'd9
    } state_t;

    localparam int CNT_W = $clog2(NUM_WORDS + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_WORDS - 1);
    localparam logic [OUT_W-1:0] MAX_C  = OUT_W'(MAX_OUTSTANDING);

    state_t            state;
    logic [1:0]        pre_button;
    logic              trigger;
    logic              err_flag;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  received;
    logic [CNT_W-1:0]  issued_nx;
    logic [CNT_W-1:0]  received_nx;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  outstanding_nx;
    logic [ADDR_W-1:0] check_addr;
    logic [DATA_W-1:0] expected;
    logic              accept;
    logic              ret;
    logic              mismatch;

    always_comb begin
        accept         = avl.avl_read && avl.avl_waitrequest_n;
        ret            = avl.avl_readdatavalid
                         && (state == READ || state == DRAIN);
        issued_nx      = issued + CNT_W'(accept);
        received_nx    = received + CNT_W'(ret);
        outstanding_nx = outstanding + OUT_W'(accept) - OUT_W'(ret);
        expected       = DATA_W'(check_addr);
        mismatch       = ret && (avl.avl_readdata != expected);
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state           <= IDLE;
            pre_button      <= 2'b11;
            trigger         <= 1'b0;
            err_flag        <= 1'b0;
            err_count       <= 16'd0;
            first_err_addr  <= '0;
            issued          <= '0;
            received        <= '0;
            outstanding     <= '0;
            check_addr      <= '0;
            avl.avl_address <= '0;
            avl.avl_read    <= 1'b0;
        end else begin
            pre_button <= {pre_button[0], iBUTTON};
            trigger    <= pre_button[1] & ~pre_button[0];
            if (mismatch) begin
                if (err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
                if (!err_flag)
                    first_err_addr <= check_addr;
                err_flag <= 1'b1;
            end
            if (ret)
                check_addr <= check_addr + ADDR_W'(1);
            case (state)
                IDLE: begin
                    if (local_init_done && trigger) begin
                        err_flag        <= 1'b0;
                        err_count       <= 16'd0;
                        first_err_addr  <= '0;
                        issued          <= '0;
                        received        <= '0;
                        outstanding     <= '0;
                        check_addr      <= '0;
                        avl.avl_address <= '0;
                        avl.avl_read    <= 1'b1;
                        state           <= READ;
                    end
                end
                READ: begin
                    issued      <= issued_nx;
                    received    <= received_nx;
                    outstanding <= outstanding_nx;
                    if (accept)
                        avl.avl_address <= avl.avl_address + ADDR_W'(1);
                    // Last accept ends issuing regardless of free slots
                    if (accept && issued == LAST_C) begin
                        avl.avl_read <= 1'b0;
                        state        <= DRAIN;
                    end else begin
                        avl.avl_read <= (issued_nx < NUM_C)
                                        && (outstanding_nx < MAX_C);
                    end
                end
                DRAIN: begin
                    received    <= received_nx;
                    outstanding <= outstanding_nx;
                    if (received_nx == NUM_C)
                        state <= DONE;
                end
                DONE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign avl.avl_burstbegin       = avl.avl_read;
    assign c_state                  = state;
    assign drv_status_test_complete = (state == DONE);
    assign drv_status_test_pass     = (state == DONE) && !err_flag;
endmodule
